// File: rtl/seq_divider8.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_divider8 : sequential unsigned restoring divider, one bit per clock |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zpend_q, zpend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] qsh_next;
  logic             accept;

  // Trial subtraction by two's-complement addition; the top bit flags a borrow.
  always_comb begin
    rem_shift = {rem_q, qsh_q[WIDTH-1]};
    trial     = rem_shift + ~{1'b0, dvs_q} + (WIDTH+1)'(1);
    borrow    = trial[WIDTH];
    rem_next  = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    qsh_next  = {qsh_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d     = state_q;
    qsh_d       = qsh_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    count_d     = count_q;
    zpend_d     = zpend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    accept = start && !zpend_q && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        // A zero divisor spends one idle cycle before reporting its result.
        if (zpend_q) begin
          quotient_d  = '1;
          remainder_d = qsh_q;
          dbz_d       = 1'b1;
          zpend_d     = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_RUN: begin
        qsh_d   = qsh_next;
        rem_d   = rem_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          quotient_d  = qsh_next;
          remainder_d = rem_next;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      qsh_d   = dividend;
      dvs_d   = divisor;
      rem_d   = '0;
      count_d = '0;
      dbz_d   = 1'b0;
      if (divisor == '0) begin
        zpend_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      qsh_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      zpend_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qsh_q       <= qsh_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      zpend_q     <= zpend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
